alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter MULTI_LAT, default 4: cycles the operands are held on the ALU for VDIV (001110), VMOD (001111) and VSQRT (010010); legal range 1..15.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream instruction valid.
REQ-005 in_ready  output  1  unit can accept an instruction this cycle.
REQ-006 in_rA, in_rB  input  [0:63] each  source operands, bit 0 = MSB.
REQ-007 in_func  input  [0:5]  function code, same encoding as the ALU (VAND=000001 .. VSQRT=010010).
REQ-008 in_ww  input  [0:1]  element width: 00 byte, 01 half, 10 word, 11 dword.
REQ-009 in_rd_addr  input  [0:4]  destination register tag.
REQ-010 alu_rA, alu_rB  output  [0:63] each  registered operands driven to the ALU rAex/rBex.
REQ-011 alu_func  output  [0:5], alu_ww  output  [0:1]  registered to ALU functionCodeEX/wwEX.
REQ-012 alu_rD  input  [0:63]  combinational ALU result rDex.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_rD  output  [0:63], out_rd_addr  output  [0:4], out_illegal  output  1  result, tag, illegal flag.
REQ-016 op_count  output  [0:15]  completed-result counter.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, DONE.
REQ-018 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; 0 otherwise.
REQ-019 Accept = in_valid & in_ready; on accept, in_rA/in_rB/in_func/in_ww/in_rd_addr SHALL be registered into alu_* and the tag register.
REQ-020 Illegal instruction: in_func=000000, in_func>010010, or in_ww=11 with VMULEU/VMULOU/VSQEU/VSQOU.
REQ-021 Legal accept SHALL enter HOLD with 4-bit counter = MULTI_LAT-1 for VDIV/VMOD/VSQRT, else 0.
REQ-022 Illegal accept SHALL go directly to DONE with out_rD=0, out_illegal=1.
REQ-023 HOLD: counter decrements each cycle; when counter=0, alu_rD SHALL be captured into out_rD, out_illegal=0, state -> DONE.
REQ-024 Latency: single-cycle op accepted at cycle N gives out_valid at N+2; long op gives out_valid at N+1+MULTI_LAT; illegal op gives out_valid at N+1.
REQ-025 alu_* outputs SHALL stay constant from accept until the next accept; they do not change during HOLD or DONE.
REQ-026 out_valid SHALL be 1 only in DONE; out_rD, out_rd_addr and out_illegal SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 DONE with out_ready=1: if in_valid=1, the new instruction is accepted in the same cycle (back-to-back) and the state moves to HOLD or DONE per REQ-021/022; otherwise the state moves to IDLE.
REQ-028 op_count SHALL increment by 1 on each out_valid & out_ready, including illegal results, and wrap from FFFF to 0000.
REQ-029 in_valid while in_ready=0 SHALL be ignored; no upstream buffering.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE with counter=0, alu_rA=alu_rB=0, alu_func=0, alu_ww=0, out_rD=0, out_rd_addr=0, out_illegal=0, out_valid=0, op_count=0; in_ready=1 once reset_n=1.
REQ-031 Reset asserted in HOLD or DONE SHALL discard the in-flight instruction; no result is produced.

Verification (bench instantiates the real alu)
REQ-032 VAND dMode, rA=rB=FFFFFFFFFFFFFFFF, accept at N, out_ready=1 -> out_valid at N+2, out_rD=FFFFFFFFFFFFFFFF, op_count=1.
REQ-033 VADD bMode, rA=FFFFFFFFFFFFFFFF, rB=0101010101010101 -> out_rD=0000000000000000 at N+2; alu_* constant through DONE.
REQ-034 VDIV wMode, MULTI_LAT=4 -> out_valid first at N+5, out_rD equals the ALU result, alu_rA/alu_rB unchanged for cycles N+1..N+5.
REQ-035 VMULEU dMode -> out_valid at N+1, out_illegal=1, out_rD=0.
REQ-036 out_ready held 0 for 3 cycles in DONE -> out_valid, out_rD and out_rd_addr held, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept, op_count increments exactly once.
REQ-037 reset_n pulsed low during HOLD of VSQRT -> all outputs reset, no out_valid, op_count=0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: single-entry issue/retire wrapper around a combinational SIMD ALU.
// The operands are latched on accept and held on the ALU for one cycle (or
// MULTI_LAT cycles for divide/modulo/sqrt). Then the result is parked in an
// output register until downstream takes it.
module alu_issue #(
  parameter int MULTI_LAT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] in_rA,
  input  logic [0:63] in_rB,
  input  logic [0:5]  in_func,
  input  logic [0:1]  in_ww,
  input  logic [0:4]  in_rd_addr,
  output logic [0:63] alu_rA,
  output logic [0:63] alu_rB,
  output logic [0:5]  alu_func,
  output logic [0:1]  alu_ww,
  input  logic [0:63] alu_rD,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_rD,
  output logic [0:4]  out_rd_addr,
  output logic        out_illegal,
  output logic [0:15] op_count
);

  localparam logic [5:0] F_VMULEU = 6'b001000;
  localparam logic [5:0] F_VMULOU = 6'b001001;
  localparam logic [5:0] F_VDIV   = 6'b001110;
  localparam logic [5:0] F_VMOD   = 6'b001111;
  localparam logic [5:0] F_VSQEU  = 6'b010000;
  localparam logic [5:0] F_VSQOU  = 6'b010001;
  localparam logic [5:0] F_VSQRT  = 6'b010010;
  localparam logic [3:0] LONG_CNT = 4'(MULTI_LAT - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:63] rA_q, rB_q, rD_q;
  logic [0:5]  func_q;
  logic [0:1]  ww_q;
  logic [0:4]  tag_q;
  logic        ill_q;
  logic [0:15] cnt_ops_q;

  logic        accept, illegal, is_long, capture, retire;

  // Decode of the incoming instruction: illegal codes and long-latency ops.
  always_comb begin
    illegal = (in_func == 6'b000000) || (in_func > F_VSQRT) ||
              ((in_ww == 2'b11) && ((in_func == F_VMULEU) || (in_func == F_VMULOU) ||
                                    (in_func == F_VSQEU)  || (in_func == F_VSQOU)));
    is_long = (in_func == F_VDIV) || (in_func == F_VMOD) || (in_func == F_VSQRT);
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign retire    = out_valid && out_ready;
  assign capture   = (state_q == HOLD) && (cnt_q == 4'd0);

  // Next-state and hold counter; an accept always wins, including back-to-back out of DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = illegal ? DONE : HOLD;
      cnt_d   = (!illegal && is_long) ? LONG_CNT : 4'd0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == 4'd0) state_d = DONE;
          else               cnt_d   = cnt_q - 4'd1;
        end
        DONE:    if (out_ready) state_d = IDLE;
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand/tag latch: changes only on accept so the ALU inputs stay still until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rA_q   <= '0;
      rB_q   <= '0;
      func_q <= '0;
      ww_q   <= '0;
      tag_q  <= '0;
    end else if (accept) begin
      rA_q   <= in_rA;
      rB_q   <= in_rB;
      func_q <= in_func;
      ww_q   <= in_ww;
      tag_q  <= in_rd_addr;
    end
  end

  // Result register: zero/illegal on an illegal accept, otherwise the ALU output at the end of HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rD_q  <= '0;
      ill_q <= 1'b0;
    end else if (accept && illegal) begin
      rD_q  <= '0;
      ill_q <= 1'b1;
    end else if (capture) begin
      rD_q  <= alu_rD;
      ill_q <= 1'b0;
    end
  end

  // Completed-result counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt_ops_q <= '0;
    else if (retire) cnt_ops_q <= cnt_ops_q + 16'd1;
  end

  assign alu_rA      = rA_q;
  assign alu_rB      = rB_q;
  assign alu_func    = func_q;
  assign alu_ww      = ww_q;
  assign out_rD      = rD_q;
  assign out_rd_addr = tag_q;
  assign out_illegal = ill_q;
  assign op_count    = cnt_ops_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU on the alu_* port.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [0:63] in_rA, in_rB;
  logic [0:5]  in_func;
  logic [0:1]  in_ww;
  logic [0:4]  in_rd_addr;
  logic [0:63] alu_rA, alu_rB, alu_rD;
  logic [0:5]  alu_func;
  logic [0:1]  alu_ww;
  logic        out_valid, out_ready;
  logic [0:63] out_rD;
  logic [0:4]  out_rd_addr;
  logic        out_illegal;
  logic [0:15] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.MULTI_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rA(in_rA), .in_rB(in_rB), .in_func(in_func), .in_ww(in_ww), .in_rd_addr(in_rd_addr),
    .alu_rA(alu_rA), .alu_rB(alu_rB), .alu_func(alu_func), .alu_ww(alu_ww), .alu_rD(alu_rD),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rD(out_rD), .out_rd_addr(out_rd_addr), .out_illegal(out_illegal), .op_count(op_count)
  );

  // Behavioural subset of the ALU: VAND, lane-wise VADD, word-mode VDIV.
  function automatic logic [0:63] alu_model(input logic [0:63] a, input logic [0:63] b,
                                            input logic [0:5] f, input logic [0:1] w);
    logic [63:0] ax, bx, r;
    ax = a; bx = b; r = '0;
    case (f)
      6'b000001: r = ax & bx;
      6'b000110: begin
        case (w)
          2'b00:   for (int i = 0; i < 8; i++) r[8*i +: 8]  = ax[8*i +: 8]  + bx[8*i +: 8];
          2'b01:   for (int i = 0; i < 4; i++) r[16*i +: 16] = ax[16*i +: 16] + bx[16*i +: 16];
          2'b10:   for (int i = 0; i < 2; i++) r[32*i +: 32] = ax[32*i +: 32] + bx[32*i +: 32];
          default: r = ax + bx;
        endcase
      end
      6'b001110: begin
        r[63:32] = (bx[63:32] != 0) ? ax[63:32] / bx[63:32] : 32'd0;
        r[31:0]  = (bx[31:0]  != 0) ? ax[31:0]  / bx[31:0]  : 32'd0;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb alu_rD = alu_model(alu_rA, alu_rB, alu_func, alu_ww);

  task automatic issue(input logic [0:63] a, input logic [0:63] b, input logic [0:5] f,
                       input logic [0:1] w, input logic [0:4] t);
    @(negedge clk);
    in_rA = a; in_rB = b; in_func = f; in_ww = w; in_rd_addr = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid; 50 means it never came.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rA = '0; in_rB = '0; in_func = '0; in_ww = '0; in_rd_addr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || op_count !== 16'h0 || alu_rA !== 64'h0 || alu_rB !== 64'h0 ||
        alu_func !== 6'h0 || alu_ww !== 2'b0 || out_rD !== 64'h0 || out_rd_addr !== 5'h0 ||
        out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state valid=%b cnt=%h rA=%h rD=%h tag=%h ill=%b exp all zero",
               out_valid, op_count, alu_rA, out_rD, out_rd_addr, out_illegal);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_single_and;
    int lat;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000001, 2'b11, 5'd3);
    wait_valid(lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL and_latency got %0d exp 1", lat); end
    checks++;
    if (out_rD !== 64'hFFFF_FFFF_FFFF_FFFF || out_rd_addr !== 5'd3 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL and_result got rD=%h tag=%0d ill=%b exp FFFFFFFFFFFFFFFF 3 0",
               out_rD, out_rd_addr, out_illegal);
    end
    @(posedge clk); #1;
    checks++;
    if (op_count !== 16'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL and_retire got cnt=%0d valid=%b exp 1 0", op_count, out_valid);
    end
  endtask

  task automatic test_add_byte;
    int lat;
    int bad = 0;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 6'b000110, 2'b00, 5'd4);
    if (alu_rA !== 64'hFFFF_FFFF_FFFF_FFFF || alu_rB !== 64'h0101_0101_0101_0101 ||
        alu_func !== 6'b000110 || alu_ww !== 2'b00) bad++;
    wait_valid(lat);
    if (alu_rA !== 64'hFFFF_FFFF_FFFF_FFFF || alu_rB !== 64'h0101_0101_0101_0101 ||
        alu_func !== 6'b000110 || alu_ww !== 2'b00) bad++;
    checks++;
    if (lat != 1 || out_rD !== 64'h0) begin
      errors++; $display("FAIL add_result got lat=%0d rD=%h exp 1 0000000000000000", lat, out_rD);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL add_alu_hold got %0d changes exp 0", bad); end
    @(posedge clk); #1;
    checks++;
    if (op_count !== 16'd2) begin errors++; $display("FAIL add_count got %0d exp 2", op_count); end
  endtask

  task automatic test_div_long;
    int lat = 0;
    int bad = 0;
    issue({32'd100, 32'd81}, {32'd7, 32'd9}, 6'b001110, 2'b10, 5'd5);
    // One sample per cycle N+1..N+5; out_valid expected first in N+5.
    while (!out_valid && lat < 50) begin
      if (alu_rA !== {32'd100, 32'd81} || alu_rB !== {32'd7, 32'd9}) bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (alu_rA !== {32'd100, 32'd81} || alu_rB !== {32'd7, 32'd9}) bad++;
    checks++;
    if (lat != 4) begin errors++; $display("FAIL div_latency got %0d exp 4", lat); end
    checks++;
    if (out_rD !== 64'h0000_000E_0000_0009 || out_rd_addr !== 5'd5) begin
      errors++; $display("FAIL div_result got rD=%h tag=%0d exp 0000000E00000009 5", out_rD, out_rd_addr);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL div_alu_hold got %0d changes exp 0", bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    int lat;
    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 6'b001000, 2'b11, 5'd6);
    wait_valid(lat);
    checks++;
    if (lat != 0 || out_illegal !== 1'b1 || out_rD !== 64'h0 || out_rd_addr !== 5'd6) begin
      errors++;
      $display("FAIL mul_dword_illegal got lat=%0d ill=%b rD=%h tag=%0d exp 0 1 0 6",
               lat, out_illegal, out_rD, out_rd_addr);
    end
    @(posedge clk); #1;
    issue(64'h5, 64'h6, 6'b010011, 2'b00, 5'd7);
    wait_valid(lat);
    checks++;
    if (lat != 0 || out_illegal !== 1'b1 || out_rD !== 64'h0) begin
      errors++; $display("FAIL func_range_illegal got lat=%0d ill=%b rD=%h exp 0 1 0", lat, out_illegal, out_rD);
    end
    @(posedge clk); #1;
    checks++;
    if (op_count !== 16'd5) begin errors++; $display("FAIL illegal_count got %0d exp 5", op_count); end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b0;
    issue(64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_0000_FFFF_0000, 6'b000001, 2'b11, 5'd7);
    wait_valid(lat);
    // Offer the next instruction during the stall; it must not be taken yet.
    in_rA = 64'd1; in_rB = 64'd2; in_func = 6'b000110; in_ww = 2'b11; in_rd_addr = 5'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rD !== 64'h0F0F_0000_0F0F_0000 ||
          out_rd_addr !== 5'd7 || alu_rA !== 64'h0F0F_0F0F_0F0F_0F0F) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got valid=%b rdy=%b rD=%h tag=%0d rA=%h exp 1 0 0F0F00000F0F0000 7 0F0F0F0F0F0F0F0F",
                 i, out_valid, in_ready, out_rD, out_rd_addr, alu_rA);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (op_count !== 16'd6 || out_valid !== 1'b0 || alu_rA !== 64'd1) begin
      errors++; $display("FAIL b2b_accept got cnt=%0d valid=%b rA=%h exp 6 0 1", op_count, out_valid, alu_rA);
    end
    wait_valid(lat);
    checks++;
    if (lat != 1 || out_rD !== 64'd3 || out_rd_addr !== 5'd9) begin
      errors++; $display("FAIL b2b_result got lat=%0d rD=%h tag=%0d exp 1 3 9", lat, out_rD, out_rd_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (op_count !== 16'd7) begin errors++; $display("FAIL b2b_count got %0d exp 7", op_count); end
  endtask

  task automatic test_reset_hold;
    int seen = 0;
    issue(64'd49, 64'd0, 6'b010010, 2'b11, 5'd10);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== 16'h0 || alu_rA !== 64'h0 || alu_func !== 6'h0 ||
        alu_ww !== 2'b0 || out_rd_addr !== 5'h0 || out_illegal !== 1'b0 || out_rD !== 64'h0) begin
      errors++;
      $display("FAIL hold_reset got valid=%b cnt=%0d rA=%h func=%h tag=%0d exp all zero",
               out_valid, op_count, alu_rA, alu_func, out_rd_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || op_count !== 16'h0) begin
      errors++; $display("FAIL hold_discard got %0d valid cycles cnt=%0d exp 0 0", seen, op_count);
    end
  endtask

  initial begin
    test_reset;
    test_single_and;
    test_add_byte;
    test_div_long;
    test_illegal;
    test_back_to_back;
    test_reset_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
